// File: rtl/serdesphy_rx_frame_sync.sv
// serdesphy_rx_frame_sync
// Frame synchroniser for the RX nibble stream in the 24 MHz domain.
// It hunts for SYNC_BYTE on any nibble boundary and then assembles bytes.
// The frame format is SYNC, LEN, LEN payload bytes, XOR checksum.
// Payload is forwarded before the checksum is verified. The verdict and the
// frame-lock status follow the checksum byte.
// Optional feature: define SERDESPHY_FRAME_SYNC_CNT_EN to add the saturating
// good_frame_cnt and bad_frame_cnt frame counters.
module serdesphy_rx_frame_sync #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         LOCK_FRAMES = 2,
    parameter int         LOSS_FRAMES = 2
) (
    input  logic       clk_24m,
    input  logic       rst_24m,
    input  logic       enable,
    input  logic       resync,
    input  logic [3:0] nibble_in,
    input  logic       nibble_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_sof,
    output logic       byte_eof,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       sync_locked,
    output logic [1:0] fsm_state
`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
    ,
    output logic [7:0] good_frame_cnt,
    output logic [7:0] bad_frame_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [2:0] LOCK_B    = 3'(LOCK_FRAMES);
    localparam logic [2:0] LOSS_B    = 3'(LOSS_FRAMES);

    state_t     state_reg, state_next;
    // Only the low half of the byte window feeds the sync match, because the
    // incoming nibble supplies the other half. So only that half is stored.
    logic [3:0] win_lo_reg, win_lo_next;
    logic       phase_reg, phase_next;
    logic [3:0] hi_reg, hi_next;
    logic [7:0] remaining_reg, remaining_next;
    logic [7:0] csum_reg, csum_next;
    logic       first_reg, first_next;
    logic [2:0] good_run_reg, good_run_next;
    logic [2:0] bad_run_reg, bad_run_next;
    logic       locked_reg, locked_next;
    logic [7:0] byte_out_reg, byte_out_next;
    logic       byte_valid_reg, byte_valid_next;
    logic       sof_reg, sof_next;
    logic       eof_reg, eof_next;
    logic       ok_reg, ok_next;
    logic       err_reg, err_next;

    logic [7:0] window;
    logic [7:0] cur_byte;
    logic [2:0] good_inc;
    logic [2:0] bad_inc;

    assign window   = {win_lo_reg, nibble_in};
    assign cur_byte = {hi_reg, nibble_in};
    assign good_inc = (good_run_reg == 3'd7) ? 3'd7 : good_run_reg + 3'd1;
    assign bad_inc  = (bad_run_reg == 3'd7) ? 3'd7 : bad_run_reg + 3'd1;

    // State register: every output and piece of parsing context is registered here.
    always_ff @(posedge clk_24m) begin
        if (rst_24m) begin
            state_reg      <= ST_HUNT;
            win_lo_reg     <= 4'h0;
            phase_reg      <= 1'b0;
            hi_reg         <= 4'h0;
            remaining_reg  <= 8'h00;
            csum_reg       <= 8'h00;
            first_reg      <= 1'b0;
            good_run_reg   <= 3'd0;
            bad_run_reg    <= 3'd0;
            locked_reg     <= 1'b0;
            byte_out_reg   <= 8'h00;
            byte_valid_reg <= 1'b0;
            sof_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            ok_reg         <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            win_lo_reg     <= win_lo_next;
            phase_reg      <= phase_next;
            hi_reg         <= hi_next;
            remaining_reg  <= remaining_next;
            csum_reg       <= csum_next;
            first_reg      <= first_next;
            good_run_reg   <= good_run_next;
            bad_run_reg    <= bad_run_next;
            locked_reg     <= locked_next;
            byte_out_reg   <= byte_out_next;
            byte_valid_reg <= byte_valid_next;
            sof_reg        <= sof_next;
            eof_reg        <= eof_next;
            ok_reg         <= ok_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic: the sync hunt, byte assembly, frame parsing and lock tracking.
    always_comb begin
        state_next      = state_reg;
        win_lo_next     = win_lo_reg;
        phase_next      = phase_reg;
        hi_next         = hi_reg;
        remaining_next  = remaining_reg;
        csum_next       = csum_reg;
        first_next      = first_reg;
        good_run_next   = good_run_reg;
        bad_run_next    = bad_run_reg;
        locked_next     = locked_reg;
        byte_out_next   = byte_out_reg;
        byte_valid_next = 1'b0;
        sof_next        = 1'b0;
        eof_next        = 1'b0;
        ok_next         = 1'b0;
        err_next        = 1'b0;

        if (!enable || resync) begin
            // Abort without any verdict. Lock must be earned again from scratch.
            state_next     = ST_HUNT;
            win_lo_next    = 4'h0;
            phase_next     = 1'b0;
            hi_next        = 4'h0;
            remaining_next = 8'h00;
            csum_next      = 8'h00;
            first_next     = 1'b0;
            good_run_next  = 3'd0;
            bad_run_next   = 3'd0;
            locked_next    = 1'b0;
            if (!enable) begin
                byte_out_next = 8'h00;
            end
        end else if (nibble_valid) begin
            win_lo_next = nibble_in;
            if (state_reg == ST_HUNT) begin
                if (window == SYNC_BYTE) begin
                    state_next = ST_LEN;
                    phase_next = 1'b0;
                end
            end else if (!phase_reg) begin
                hi_next    = nibble_in;
                phase_next = 1'b1;
            end else begin
                phase_next = 1'b0;
                case (state_reg)
                    ST_LEN: begin
                        if (cur_byte == 8'h00 || cur_byte > MAX_LEN_B) begin
                            err_next    = 1'b1;
                            state_next  = ST_HUNT;
                            win_lo_next = 4'h0;
                        end else begin
                            remaining_next = cur_byte;
                            csum_next      = cur_byte;
                            first_next     = 1'b1;
                            state_next     = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        byte_out_next   = cur_byte;
                        byte_valid_next = 1'b1;
                        sof_next        = first_reg;
                        eof_next        = (remaining_reg == 8'd1);
                        first_next      = 1'b0;
                        csum_next       = csum_reg ^ cur_byte;
                        remaining_next  = remaining_reg - 8'd1;
                        if (remaining_reg == 8'd1) begin
                            state_next = ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (cur_byte == csum_reg) begin
                            ok_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                        state_next  = ST_HUNT;
                        win_lo_next = 4'h0;
                    end
                    default: begin
                        state_next = ST_HUNT;
                    end
                endcase
            end

            // Lock hysteresis. Both run counters saturate at 7.
            if (ok_next) begin
                good_run_next = good_inc;
                bad_run_next  = 3'd0;
                if (good_inc >= LOCK_B) begin
                    locked_next = 1'b1;
                end
            end
            if (err_next) begin
                bad_run_next  = bad_inc;
                good_run_next = 3'd0;
                if (locked_reg && bad_inc >= LOSS_B) begin
                    locked_next = 1'b0;
                end
            end
        end
    end

    assign byte_out    = byte_out_reg;
    assign byte_valid  = byte_valid_reg;
    assign byte_sof    = sof_reg;
    assign byte_eof    = eof_reg;
    assign frame_ok    = ok_reg;
    assign frame_err   = err_reg;
    assign sync_locked = locked_reg;
    assign fsm_state   = state_reg;

`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
    logic [7:0] good_cnt_reg;
    logic [7:0] bad_cnt_reg;

    // Lifetime frame statistics. Only rst_24m clears them.
    always_ff @(posedge clk_24m) begin
        if (rst_24m) begin
            good_cnt_reg <= 8'h00;
            bad_cnt_reg  <= 8'h00;
        end else begin
            if (ok_next && good_cnt_reg != 8'hFF) begin
                good_cnt_reg <= good_cnt_reg + 8'd1;
            end
            if (err_next && bad_cnt_reg != 8'hFF) begin
                bad_cnt_reg <= bad_cnt_reg + 8'd1;
            end
        end
    end

    assign good_frame_cnt = good_cnt_reg;
    assign bad_frame_cnt  = bad_cnt_reg;
`endif

endmodule

// File: tb/tb_serdesphy_rx_frame_sync.sv
// Testbench for serdesphy_rx_frame_sync.
// It builds frames at byte level and derives the expected output events
// (payload bytes, verdicts, lock level and cycle) from the framing rules.
// Those events are compared against the events captured from the DUT.
module tb_serdesphy_rx_frame_sync;

    localparam int MAX_LEN     = 16;
    localparam int LOCK_FRAMES = 2;
    localparam int LOSS_FRAMES = 2;

    logic       clk_24m = 1'b0;
    logic       rst_24m = 1'b1;
    logic       enable = 1'b1;
    logic       resync = 1'b0;
    logic [3:0] nibble_in = 4'h0;
    logic       nibble_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, byte_sof, byte_eof, frame_ok, frame_err, sync_locked;
    logic [1:0] fsm_state;
`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
    logic [7:0] good_frame_cnt, bad_frame_cnt;
`endif

    serdesphy_rx_frame_sync #(
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (MAX_LEN),
        .LOCK_FRAMES(LOCK_FRAMES),
        .LOSS_FRAMES(LOSS_FRAMES)
    ) dut (
        .clk_24m     (clk_24m),
        .rst_24m     (rst_24m),
        .enable      (enable),
        .resync      (resync),
        .nibble_in   (nibble_in),
        .nibble_valid(nibble_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_sof    (byte_sof),
        .byte_eof    (byte_eof),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .sync_locked (sync_locked),
        .fsm_state   (fsm_state)
`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
        ,
        .good_frame_cnt(good_frame_cnt),
        .bad_frame_cnt (bad_frame_cnt)
`endif
    );

    always #5 clk_24m = ~clk_24m;

    int cyc = 0;
    always @(posedge clk_24m) cyc = cyc + 1;

    // kind: 0 = payload byte, 1 = frame_ok, 2 = frame_err
    typedef struct {
        int kind;
        int data;
        int sof;
        int eof;
        int locked;
        int cyc;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int last_cyc = 0;

    // Frame-level model state
    int model_good = 0;
    int model_bad = 0;
    int model_locked = 0;
    logic [7:0] pl_buf [0:255];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Capture every DUT output event, away from the active edge.
    always @(negedge clk_24m) begin
        ev_t e;
        if (!rst_24m) begin
            if (byte_valid) begin
                e.kind = 0; e.data = int'(byte_out); e.sof = int'(byte_sof);
                e.eof = int'(byte_eof); e.locked = int'(sync_locked); e.cyc = cyc;
                got_q.push_back(e);
            end
            if (frame_ok) begin
                e.kind = 1; e.data = 0; e.sof = 0; e.eof = 0;
                e.locked = int'(sync_locked); e.cyc = cyc;
                got_q.push_back(e);
            end
            if (frame_err) begin
                e.kind = 2; e.data = 0; e.sof = 0; e.eof = 0;
                e.locked = int'(sync_locked); e.cyc = cyc;
                got_q.push_back(e);
            end
        end
    end

    task automatic exp_push(input int kind, input int data, input int sof, input int eof);
        ev_t e;
        e.kind = kind; e.data = data; e.sof = sof; e.eof = eof;
        e.locked = model_locked; e.cyc = last_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_verdict(input bit ok);
        if (ok) begin
            model_good = (model_good < 7) ? model_good + 1 : 7;
            model_bad = 0;
            if (model_good >= LOCK_FRAMES) model_locked = 1;
        end else begin
            model_bad = (model_bad < 7) ? model_bad + 1 : 7;
            model_good = 0;
            if (model_locked == 1 && model_bad >= LOSS_FRAMES) model_locked = 0;
        end
        exp_push(ok ? 1 : 2, 0, 0, 0);
    endtask

    task automatic model_clear();
        model_good = 0;
        model_bad = 0;
        model_locked = 0;
    endtask

    task automatic drive_nib(input logic [3:0] n, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_24m); #1;
            resync = 1'b0;
            nibble_valid = 1'b0;
            nibble_in = 4'($urandom);
        end
        @(posedge clk_24m); #1;
        resync = 1'b0;
        nibble_valid = 1'b1;
        nibble_in = n;
        last_cyc = cyc;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gapmax);
        drive_nib(b[7:4], $urandom_range(0, gapmax));
        drive_nib(b[3:0], $urandom_range(0, gapmax));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_24m); #1;
            resync = 1'b0;
            nibble_valid = 1'b0;
        end
    endtask

    // Sends optional junk (which never contains A then 5), then one frame.
    // The expected events are queued as the frame is sent.
    task automatic send_frame(input int len, input logic [7:0] flip, input int junk,
                              input int gapmax, input bit rnd);
        logic [7:0] cs;
        logic [3:0] prev;
        logic [3:0] n;
        prev = 4'h0;
        for (int j = 0; j < junk; j++) begin
            do begin
                n = 4'($urandom);
            end while (prev == 4'hA && n == 4'h5);
            drive_nib(n, $urandom_range(0, gapmax));
            prev = n;
        end
        drive_nib(4'hA, $urandom_range(0, gapmax));
        drive_nib(4'h5, $urandom_range(0, gapmax));
        drive_byte(8'(len), gapmax);
        if (len == 0 || len > MAX_LEN) begin
            model_verdict(1'b0);
            return;
        end
        cs = 8'(len);
        for (int i = 0; i < len; i++) begin
            if (rnd) pl_buf[i] = 8'($urandom);
            drive_byte(pl_buf[i], gapmax);
            exp_push(0, int'(pl_buf[i]), (i == 0) ? 1 : 0, (i == len - 1) ? 1 : 0);
            cs = cs ^ pl_buf[i];
        end
        drive_byte(cs ^ flip, gapmax);
        model_verdict(flip == 8'h00);
    endtask

    task automatic load_demo();
        pl_buf[0] = 8'h11;
        pl_buf[1] = 8'h22;
        pl_buf[2] = 8'h33;
    endtask

    // Sends SYNC, LEN=3 and the first payload byte 0x11, then stops.
    task automatic partial_frame();
        drive_nib(4'hA, 0); drive_nib(4'h5, 0);
        drive_nib(4'h0, 0); drive_nib(4'h3, 0);
        drive_nib(4'h1, 0); drive_nib(4'h1, 0);
        exp_push(0, 8'h11, 1, 0);
    endtask

    task automatic compare_events(input string name);
        int n;
        idle(4);
        check({name, "_ev_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_ev"},
                  64'({got_q[i].kind[3:0], got_q[i].data[7:0], got_q[i].sof[0], got_q[i].eof[0], got_q[i].locked[0]}),
                  64'({exp_q[i].kind[3:0], exp_q[i].data[7:0], exp_q[i].sof[0], exp_q[i].eof[0], exp_q[i].locked[0]}));
            check({name, "_ev_cycle"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_24m); #1;
        rst_24m = 1'b1;
        enable = 1'b1;
        resync = 1'b0;
        nibble_valid = 1'b0;
        repeat (3) @(posedge clk_24m);
        #1;
        rst_24m = 1'b0;
        model_clear();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int kind;
        do_reset();

        // Reset state
        @(negedge clk_24m);
        check("rst_byte_valid", 64'(byte_valid), 64'(0));
        check("rst_byte_out", 64'(byte_out), 64'(0));
        check("rst_sof_eof", 64'({byte_sof, byte_eof}), 64'(0));
        check("rst_verdict", 64'({frame_ok, frame_err}), 64'(0));
        check("rst_locked", 64'(sync_locked), 64'(0));
        check("rst_fsm_state", 64'(fsm_state), 64'(0));

        // Aligned frame A,5,0,3,1,1,2,2,3,3,0,3
        load_demo();
        send_frame(3, 8'h00, 0, 0, 1'b0);
        compare_events("aligned");
        check("aligned_fsm_hunt", 64'(fsm_state), 64'(0));

        // Nibble offset: a leading 7 must not disturb alignment
        drive_nib(4'h7, 0);
        send_frame(3, 8'h00, 0, 0, 1'b0);
        compare_events("offset");

        // False sync: A,7,5 must not enter LEN
        drive_nib(4'hA, 0); drive_nib(4'h7, 0); drive_nib(4'h5, 0);
        idle(1);
        @(negedge clk_24m);
        check("false_sync_fsm", 64'(fsm_state), 64'(0));
        compare_events("false_sync");

        // Bad checksum: the final nibbles are 0,4 instead of 0,3
        send_frame(3, 8'h07, 0, 0, 1'b0);
        compare_events("bad_csum");

        // Illegal lengths, then a good frame
        do_reset();
        send_frame(0, 8'h00, 0, 0, 1'b0);
        send_frame(8'h11, 8'h00, 0, 0, 1'b0);
        send_frame(3, 8'h00, 0, 0, 1'b0);
        compare_events("illegal_len");

        // Lock acquisition and loss
        do_reset();
        send_frame(3, 8'h00, 0, 1, 1'b0);
        send_frame(3, 8'h00, 0, 1, 1'b0);
        send_frame(3, 8'h07, 0, 1, 1'b0);
        send_frame(3, 8'h07, 0, 1, 1'b0);
        compare_events("lock");

        // resync after payload byte 0x11. The nibble A in the resync cycle must be dropped.
        do_reset();
        partial_frame();
        @(posedge clk_24m); #1;
        resync = 1'b1;
        nibble_valid = 1'b1;
        nibble_in = 4'hA;
        model_clear();
        drive_nib(4'h5, 0);
        send_frame(3, 8'h00, 0, 0, 1'b0);
        compare_events("resync");
`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
        check("resync_good_cnt", 64'(good_frame_cnt), 64'(1));
        check("resync_bad_cnt", 64'(bad_frame_cnt), 64'(0));
`endif

        // enable low mid-frame while locked. Valid nibbles must be ignored.
        send_frame(3, 8'h00, 0, 0, 1'b0);
        send_frame(3, 8'h00, 0, 0, 1'b0);
        partial_frame();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_24m); #1;
            enable = 1'b0;
            nibble_valid = 1'b1;
            nibble_in = (i[0] == 1'b0) ? 4'hA : 4'h5;
        end
        model_clear();
        @(negedge clk_24m);
        check("dis_locked", 64'(sync_locked), 64'(0));
        check("dis_fsm_state", 64'(fsm_state), 64'(0));
        check("dis_outputs", 64'({byte_valid, byte_out, frame_ok, frame_err}), 64'(0));
        @(posedge clk_24m); #1;
        enable = 1'b1;
        nibble_valid = 1'b0;
        send_frame(3, 8'h00, 0, 0, 1'b0);
        compare_events("enable");
`ifdef SERDESPHY_FRAME_SYNC_CNT_EN
        check("enable_good_cnt", 64'(good_frame_cnt), 64'(4));
        check("enable_bad_cnt", 64'(bad_frame_cnt), 64'(0));
`endif

        // Randomised frames with gaps and junk between frames
        do_reset();
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                send_frame($urandom_range(1, MAX_LEN), 8'h00, $urandom_range(0, 5), 3, 1'b1);
            end else if (kind < 8) begin
                send_frame($urandom_range(1, MAX_LEN), 8'($urandom_range(1, 255)),
                           $urandom_range(0, 5), 3, 1'b1);
            end else if (kind == 8) begin
                send_frame(0, 8'h00, $urandom_range(0, 5), 3, 1'b1);
            end else begin
                send_frame($urandom_range(MAX_LEN + 1, 255), 8'h00, $urandom_range(0, 5), 3, 1'b1);
            end
        end
        compare_events("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serdesphy_rx_frame_sync.md
Name: serdesphy_rx_frame_sync

Overview:
- Downstream consumer of the RX datapath nibble stream (rx_data/rx_valid) in the 24 MHz domain.
- Hunts for a sync byte at nibble granularity, then assembles the following nibbles into bytes.
- Parses a framed packet: SYNC, LEN, LEN payload bytes, XOR checksum.
- Emits payload bytes with start/end-of-frame markers, a per-frame verdict, and frame-level lock status for the CSR.

Parameters:
- SYNC_BYTE, 8'hA5: frame delimiter byte. Must be non-zero.
- MAX_LEN, 16: largest legal payload length in bytes. Range 1..255.
- LOCK_FRAMES, 2: consecutive good frames required to assert sync_locked. Range 1..7.
- LOSS_FRAMES, 2: consecutive bad frames while locked required to deassert sync_locked. Range 1..7.

Ports:
- clk_24m  input  1  24 MHz system clock.
- rst_24m  input  1  Reset, synchronous to clk_24m, active-high.
- enable  input  1  Block enable from CSR.
- resync  input  1  Single-cycle pulse: abort the current frame and return to hunt.
- nibble_in  input  4  Received nibble.
- nibble_valid  input  1  Nibble strobe. Gaps of any length are legal.
- byte_out  output  8  Payload byte.
- byte_valid  output  1  Payload byte strobe.
- byte_sof  output  1  Qualifies byte_valid: first payload byte of the frame.
- byte_eof  output  1  Qualifies byte_valid: last payload byte of the frame.
- frame_ok  output  1  1-cycle pulse: checksum matched.
- frame_err  output  1  1-cycle pulse: illegal length or checksum mismatch.
- sync_locked  output  1  Frame lock status (level).
- fsm_state  output  2  Current state: 0=HUNT, 1=LEN, 2=PAYLOAD, 3=CHECK.

Behaviour:
- Clock and reset: one clock, clk_24m. rst_24m is synchronous and active-high.
- Reset values: every output 0, fsm_state=HUNT; internal window, phase, counters and checksum all 0.
- Registered outputs: all outputs update the cycle after the nibble_valid cycle that caused them (latency 1). Pulses last exactly 1 cycle.
- Window: win[7:0] <= {win[3:0], nibble_in} on every accepted nibble.
- HUNT:
  - If {win[3:0], nibble_in} == SYNC_BYTE: go to LEN and set phase=0.
  - Otherwise stay in HUNT. A sync byte may start on any nibble.
- Byte assembly (LEN/PAYLOAD/CHECK):
  - phase 0: latch the high nibble, phase=1.
  - phase 1: byte = {hi, nibble_in}, phase=0, byte is complete.
- LEN, on a complete byte:
  - If 0 or > MAX_LEN: frame_err, go to HUNT.
  - Otherwise: remaining=len, csum=len, go to PAYLOAD.
- PAYLOAD, on each complete byte:
  - byte_out=byte, byte_valid=1.
  - byte_sof=1 on the first byte of the frame; byte_eof=1 when remaining==1.
  - csum ^= byte, remaining-1.
  - After the last byte, go to CHECK.
  - LEN==1 gives sof and eof together on the same byte.
- CHECK, on a complete byte:
  - byte == csum: frame_ok. Otherwise: frame_err.
  - Go to HUNT in either case.
  - The checksum byte is never emitted on byte_out.
- Verdict timing: payload is forwarded before it is verified. The verdict arrives at least 2 cycles after byte_eof.
- Lock counters: good_run and bad_run, 3 bits each, saturating.
  - frame_ok: good_run+1, bad_run=0.
  - frame_err: bad_run+1, good_run=0.
  - sync_locked sets when good_run reaches LOCK_FRAMES, i.e. in the same cycle as the qualifying frame_ok.
  - sync_locked clears when, while locked, bad_run reaches LOSS_FRAMES, in the same cycle as the qualifying frame_err.
- Returning to HUNT clears win to 8'h00, so no stale nibble can form a sync byte.
- resync:
  - Go to HUNT; clear win, phase, good_run, bad_run and sync_locked.
  - Suppress that cycle's nibble.
  - An aborted frame produces no byte_eof, no frame_ok and no frame_err.
- enable low:
  - Same clearing as resync, held continuously.
  - nibble_valid is ignored.
  - Outputs are 0 from the next cycle.
- Priority: rst_24m > enable low > resync > nibble_valid.

Optional Feature:
- Macro: SERDESPHY_FRAME_SYNC_CNT_EN.
- Defined: adds outputs good_frame_cnt[7:0] and bad_frame_cnt[7:0].
  - Each increments on frame_ok / frame_err respectively and saturates at 8'hFF.
  - Both clear on rst_24m only; they are unaffected by resync and enable.
- Undefined: ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Aligned frame: nibbles A,5,0,3,1,1,2,2,3,3,0,3 -> bytes 11(sof), 22, 33(eof); frame_ok pulse once; frame_err stays 0; fsm_state returns to 0.
- Nibble offset: 7,A,5 followed by the same frame -> identical output. False sync: nibbles A,7,5 give no LEN entry (fsm_state stays 0).
- Bad checksum: same frame with final nibbles 0,4 -> bytes 11, 22, 33 still emitted; frame_err pulse; no frame_ok.
- Illegal length: LEN=00, and separately LEN=11 with MAX_LEN=16 -> frame_err after the LEN byte, zero byte_valid; a following good frame gives frame_ok.
- Lock: two good frames -> sync_locked=1 in the second frame_ok cycle; then two bad-checksum frames -> sync_locked=0 in the second frame_err cycle.
- resync after payload byte 11, then a full good frame -> no eof or verdict for the aborted frame; new frame gives frame_ok. With the macro: good_frame_cnt=1, bad_frame_cnt=0.
